// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults and the buffered writeback entry type.
package wb_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam int STARVE_MAX = 4;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo2.sv
// wb_fifo2: 2-entry in-order FIFO for long-latency writeback entries.
// Ports: clk, rst (async active-low), push/din enqueue, pop dequeue,
// full/empty status, head = oldest entry (valid when !empty).
module wb_fifo2 import wb_pkg::*; #(
  parameter type T = wb_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);
  T mem [2];
  logic [1:0] cnt;
  logic rd, do_push, do_pop;
  assign full = cnt[1];
  assign empty = cnt == 2'd0;
  assign head = mem[rd];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // write slot is the one after the head; with a simultaneous pop at count 1
  // it becomes the new head
  always_ff @(posedge clk)
    if (do_push) mem[rd ^ cnt[0]] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= 2'd0;
      rd <= 1'b0;
    end else begin
      if (do_pop) rd <= ~rd;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and buffered long-latency results onto one RF write port.
// Ports: clk, rst (async active-low); alu_valid/alu_waddr/alu_wdata (always accepted);
// lng_valid/lng_ready/lng_waddr/lng_wdata (FIFO input); claim_valid/claim_addr
// (scoreboard reservation); busy (per-register outstanding bitmap);
// wb_stall (ALU must hold off); rf_wen/rf_waddr/rf_wdata (registered write port).
module wb_arbiter import wb_pkg::*; #(
  parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
  parameter int STARVE_MAX = wb_pkg::STARVE_MAX
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [ADDR_WIDTH-1:0]       alu_waddr,
  input  logic [DATA_WIDTH-1:0]       alu_wdata,
  input  logic                        lng_valid,
  output logic                        lng_ready,
  input  logic [ADDR_WIDTH-1:0]       lng_waddr,
  input  logic [DATA_WIDTH-1:0]       lng_wdata,
  input  logic                        claim_valid,
  input  logic [ADDR_WIDTH-1:0]       claim_addr,
  output logic [(1<<ADDR_WIDTH)-1:0]  busy,
  output logic                        wb_stall,
  output logic                        rf_wen,
  output logic [ADDR_WIDTH-1:0]       rf_waddr,
  output logic [DATA_WIDTH-1:0]       rf_wdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
  entry_t din, head;
  logic full, empty, push, pop, alu_win, wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [(1<<ADDR_WIDTH)-1:0] busy_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  assign din = '{addr: lng_waddr, data: lng_wdata};
  assign lng_ready = !full;
  assign push = lng_valid && !full;
  assign alu_win = alu_valid && !wb_stall;
  assign pop = !alu_win && !empty;
  assign wr = (alu_win || pop) && sel_addr != '0;
  // counter only advances while the head waits behind an ALU write
  assign cnt_nxt = (empty || pop) ? '0 : cnt + CW'(1);
  wb_fifo2 #(.T(entry_t)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .full(full), .empty(empty), .head(head)
  );
  always_comb begin
    sel_addr = alu_win ? alu_waddr : head.addr;
    sel_data = alu_win ? alu_wdata : head.data;
    busy_nxt = busy;
    if (pop) busy_nxt[head.addr] = 1'b0;
    if (claim_valid) busy_nxt[claim_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rf_wen <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      cnt <= '0;
      wb_stall <= 1'b0;
      busy <= '0;
    end else begin
      rf_wen <= wr;
      if (wr) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
      cnt <= cnt_nxt;
      wb_stall <= cnt_nxt == CW'(STARVE_MAX);
      busy <= busy_nxt;
    end
  a_no_alu_in_stall: assert property (@(posedge clk) disable iff (!rst) !(wb_stall && alu_valid));
  // re-claiming is legal only when the same edge retires the outstanding write
  a_no_double_claim: assert property (@(posedge clk) disable iff (!rst)
    !(claim_valid && claim_addr != '0 && busy[claim_addr] && !(pop && head.addr == claim_addr)));
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed plus randomized checks of wb_arbiter against a queue model.
module tb_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int SM = 4;
  logic clk = 0, rst = 0;
  logic alu_valid = 0, lng_valid = 0, claim_valid = 0;
  logic [AW-1:0] alu_waddr = 0, lng_waddr = 0, claim_addr = 0;
  logic [DW-1:0] alu_wdata = 0, lng_wdata = 0;
  logic lng_ready, wb_stall, rf_wen;
  logic [NR-1:0] busy;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  always #5 clk = ~clk;
  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_waddr(lng_waddr), .lng_wdata(lng_wdata),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .busy(busy), .wb_stall(wb_stall),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t q[$];
  logic [NR-1:0] m_busy;
  int m_cnt;
  logic m_stall, m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void m_reset();
    q.delete();
    m_busy = '0;
    m_cnt = 0;
    m_stall = 0;
    m_wen = 0;
    m_waddr = 0;
    m_wdata = 0;
  endfunction
  task automatic m_step();
    bit alu_w, pushed, popped;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!rst) begin
      m_reset();
      return;
    end
    alu_w = alu_valid && !m_stall;
    pushed = lng_valid && q.size() < 2;
    popped = !alu_w && q.size() > 0;
    m_wen = 0;
    if (alu_w || popped) begin
      a = alu_w ? alu_waddr : q[0].a;
      d = alu_w ? alu_wdata : q[0].d;
      if (a != 0) begin
        m_wen = 1;
        m_waddr = a;
        m_wdata = d;
      end
    end
    m_cnt = (alu_w && q.size() > 0) ? m_cnt + 1 : 0;
    m_stall = m_cnt == SM;
    if (popped) begin
      m_busy[q[0].a] = 0;
      void'(q.pop_front());
    end
    if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1;
    if (pushed) q.push_back('{lng_waddr, lng_wdata});
  endtask
  task automatic check_all();
    chk("rf_wen", 64'(rf_wen), 64'(m_wen));
    chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    chk("lng_ready", 64'(lng_ready), 64'(q.size() < 2));
    chk("wb_stall", 64'(wb_stall), 64'(m_stall));
    chk("busy", 64'(busy), 64'(m_busy));
  endtask
  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic idle();
    alu_valid = 0;
    lng_valid = 0;
    claim_valid = 0;
  endtask
  task automatic rnd();
    logic [AW-1:0] c;
    alu_valid = !m_stall && ($urandom_range(0, 9) < 6);
    alu_waddr = AW'($urandom);
    alu_wdata = $urandom;
    lng_valid = 1'($urandom_range(0, 1));
    lng_waddr = AW'($urandom);
    lng_wdata = $urandom;
    c = AW'($urandom_range(1, NR - 1));
    claim_valid = ($urandom_range(0, 3) == 0) && !m_busy[c];
    claim_addr = c;
  endtask
  initial begin
    int got;
    logic acc;
    logic [AW-1:0] order[$];
    m_reset();
    for (int i = 0; i < 3; i++) begin
      rnd();
      tick();
    end
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_ready", 64'(lng_ready), 64'(1));
    rst = 1;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_wen", 64'(rf_wen), 64'(0));
    end
    alu_valid = 1; alu_waddr = 5; alu_wdata = 32'hDEADBEEF;
    tick();
    chk("alu_wen", 64'(rf_wen), 64'(1));
    chk("alu_waddr", 64'(rf_waddr), 64'(5));
    chk("alu_wdata", 64'(rf_wdata), 64'(32'hDEADBEEF));
    idle();
    tick();
    chk("alu_wen_drop", 64'(rf_wen), 64'(0));
    alu_valid = 1; alu_waddr = 0; alu_wdata = 32'h1234;
    tick();
    chk("r0_wen", 64'(rf_wen), 64'(0));
    chk("r0_hold", 64'(rf_waddr), 64'(5));
    idle();
    claim_valid = 1; claim_addr = 7;
    tick();
    chk("claim7", 64'(busy[7]), 64'(1));
    idle();
    lng_valid = 1; lng_waddr = 7; lng_wdata = 32'h12;
    tick();
    chk("lng_not_yet", 64'(rf_wen), 64'(0));
    idle();
    tick();
    chk("lng_wen", 64'(rf_wen), 64'(1));
    chk("lng_waddr", 64'(rf_waddr), 64'(7));
    chk("lng_wdata", 64'(rf_wdata), 64'(32'h12));
    chk("clear7", 64'(busy[7]), 64'(0));
    alu_valid = 1; alu_waddr = 10; alu_wdata = 32'hA0;
    lng_valid = 1; lng_waddr = 1; lng_wdata = 32'h101;
    tick();
    lng_waddr = 2; lng_wdata = 32'h202;
    tick();
    chk("bp_ready", 64'(lng_ready), 64'(0));
    lng_waddr = 3; lng_wdata = 32'h303;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_stall", 64'(wb_stall), 64'(1));
    alu_valid = 0;
    for (int i = 0; i < 10; i++) begin
      acc = lng_valid && lng_ready;
      tick();
      if (rf_wen) order.push_back(rf_waddr);
      if (acc) lng_valid = 0;
    end
    got = 0;
    foreach (order[k]) got = got * 32 + int'(order[k]);
    chk("bp_order", 64'(got), 64'(1 * 1024 + 2 * 32 + 3));
    idle();
    claim_valid = 1; claim_addr = 9;
    tick();
    idle();
    lng_valid = 1; lng_waddr = 9; lng_wdata = 32'h99;
    tick();
    idle();
    claim_valid = 1; claim_addr = 9;
    tick();
    chk("collide_busy9", 64'(busy[9]), 64'(1));
    chk("collide_waddr", 64'(rf_waddr), 64'(9));
    idle();
    alu_valid = 1; alu_waddr = 4; alu_wdata = 32'h44;
    claim_valid = 1; claim_addr = 3;
    tick();
    claim_valid = 0;
    lng_valid = 1; lng_waddr = 3; lng_wdata = 32'h33;
    tick();
    lng_waddr = 5; lng_wdata = 32'h55;
    tick();
    idle();
    chk("pre_rst_busy3", 64'(busy[3]), 64'(1));
    chk("pre_rst_full", 64'(lng_ready), 64'(0));
    #2;
    rst = 0;
    #1;
    m_reset();
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_ready", 64'(lng_ready), 64'(1));
    chk("arst_wen", 64'(rf_wen), 64'(0));
    chk("arst_stall", 64'(wb_stall), 64'(0));
    tick();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_wen", 64'(rf_wen), 64'(0));
    end
    for (int i = 0; i < 400; i++) begin
      rnd();
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback stage directly upstream of the register file. It merges two result sources into the register file's single write port (wen/waddr/wdata):
- a fixed-latency ALU path that is always accepted;
- a long-latency path (load / mul-div) buffered in a 2-entry FIFO with valid/ready.
It also keeps a per-register busy scoreboard, so the issue stage can stall on RAW hazards against outstanding long-latency writes.

Parameters:
DATA_WIDTH, 32, result/register width (4 in the FPGA build)
ADDR_WIDTH, 5, register address width (2 in the FPGA build); NREGS = 1<<ADDR_WIDTH
STARVE_MAX, 4, max cycles a non-empty FIFO head may wait behind ALU writes before stall is forced

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result present this cycle (no ready; always accepted unless protocol violated)
alu_waddr  in  ADDR_WIDTH  ALU destination register
alu_wdata  in  DATA_WIDTH  ALU result
lng_valid  in  1  long-path result offered
lng_ready  out  1  FIFO can accept; equals !full (registered-state derived, no comb path from lng_valid)
lng_waddr  in  ADDR_WIDTH  long-path destination
lng_wdata  in  DATA_WIDTH  long-path result
claim_valid  in  1  issue stage reserves claim_addr for a long-latency op
claim_addr  in  ADDR_WIDTH  register being reserved
busy  out  NREGS  scoreboard bitmap; busy[r]=1 while a long write to r is outstanding
wb_stall  out  1  registered; upstream must not assert alu_valid while high
rf_wen  out  1  registered write enable to register file
rf_waddr  out  ADDR_WIDTH  registered write address
rf_wdata  out  DATA_WIDTH  registered write data

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied; contents discarded.
  - busy=0, starve counter=0, wb_stall=0.
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - A reset mid-operation drops every pending write; no rf_wen pulse is emitted for it.
- FIFO accept: push on posedge when lng_valid && lng_ready. Depth 2, in-order.
- Write select, evaluated each posedge:
  - if wb_stall=0 and alu_valid: ALU wins;
  - else if FIFO non-empty: pop head;
  - else: no write.
  - The selected entry is registered into rf_*, so rf_wen is high in the cycle after the edge.
  - Latency: ALU = 1 cycle. Long path = minimum 2 cycles (push at edge N, pop at N+1, rf_wen visible after N+1); no FIFO bypass.
- Push and pop in the same edge are allowed (count unchanged). A push is never accepted while full, because lng_ready=0.
- Address 0: the selected write drives rf_wen=0, and rf_waddr/rf_wdata keep their previous values. A long-path entry to r0 is still popped.
- Starvation counter:
  - increments on each edge where the FIFO is non-empty and the ALU wins;
  - resets to 0 on any pop, or when the FIFO is empty.
  - When the counter reaches STARVE_MAX, wb_stall=1 from the next cycle.
  - wb_stall clears on the edge that pops the head; the counter returns to 0.
  - alu_valid=1 while wb_stall=1 is a protocol violation: an assertion fires, the ALU input is ignored, and the FIFO pops.
- Scoreboard:
  - claim_valid with claim_addr≠0 sets busy[claim_addr] at the edge.
  - A pop of a long entry with waddr r clears busy[r] at the same edge.
  - A set and a clear of the same r at the same edge: set wins.
  - busy[0] is constantly 0.
  - A claim to an already-busy register is a protocol violation (assertion); busy stays 1.
  - ALU writes never touch busy.
- All outputs are driven from flops, except lng_ready (decoded from FIFO count) and busy (the flop vector itself).

Decomposition:
- Package wb_pkg: DATA_WIDTH, ADDR_WIDTH, NREGS, STARVE_MAX defaults; typedef wb_entry_t {addr, data}.
- Sub-module wb_fifo2:
  - 2-entry FIFO of wb_entry_t;
  - ports push/pop/full/empty/head;
  - async active-low reset.
- Arbitration, starve counter and scoreboard stay in wb_arbiter.

Test Plan:
- Reset values: hold rst=0 with random inputs → rf_wen=0, busy=0, lng_ready=1, wb_stall=0. Release; idle 3 cycles → rf_wen stays 0.
- ALU path: alu_valid with waddr=5, wdata=0xDEADBEEF at edge N → after N: rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; rf_wen=0 the following cycle. Same stimulus with waddr=0 → rf_wen=0.
- Scoreboard round trip: claim r7, then lng write to r7 = 0x12 with ALU idle:
  - busy[7]=1 after the claim edge;
  - rf_wen with r7=0x12 two cycles after the push;
  - busy[7]=0 on the pop edge.
- Back-pressure: three consecutive lng_valid (r1, r2, r3) while alu_valid is held high →
  - lng_ready=0 after the 2nd push; the 3rd is held;
  - wb_stall=1 after 4 ALU-won edges;
  - r1 is written, then ordering r1, r2, r3 is preserved.
- Claim/clear collision: r9 is busy; the pop of r9 and a new claim of r9 happen at the same edge → busy[9] remains 1.
- Async reset mid-flight: FIFO holds 2 entries, busy[3]=1; pulse rst low between edges →
  - busy=0 and FIFO empty immediately;
  - no rf_wen for the dropped entries after rst is released.
